bram_load_scheduler: RTL

- Shares the single read-only BRAM between NUM_REQ layer loaders (weight/bias loaders). Each loader requests a burst (base address, length).
- A round-robin arbiter grants one burst at a time. The scheduler issues sequential BRAM reads and absorbs the BRAM read latency with a valid-tag pipeline.
- Returned words stream back tagged with owner and element index, so loaders only pack data and no longer drive the BRAM or count latency.

---
 rtl/sched_pkg.sv | 25 ++
 rtl/bram_load_scheduler_rr_arbiter.sv | 44 ++++
 rtl/bram_load_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the BRAM load scheduler: FSM encoding, default read
// latency and the BRAM memory map of the layer loaders.
package sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } sched_state_e;

  localparam int DEFAULT_RD_LATENCY = 2;

  // Word-address regions each loader bursts from.
  localparam logic [17:0] L1_WEIGHT_BASE = 18'd0;
  localparam logic [17:0] L1_BIAS_BASE   = 18'd147552;
  localparam logic [17:0] L2_WEIGHT_BASE = 18'd147584;
  localparam logic [17:0] L2_BIAS_BASE   = 18'd155776;

endpackage

// File: rtl/bram_load_scheduler_rr_arbiter.sv
// One-hot burst arbiter: round-robin from ptr, or fixed lowest-index priority
// when SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter
  import sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [OWN_W-1:0]   idx,
  output logic               any
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SCHED_FIXED_PRIO_EN
      pos = i;
`else
      pos = (int'(ptr) + i) % NUM_REQ;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!any && k == pos && req[k]) begin
          any    = 1'b1;
          gnt[k] = 1'b1;
          idx    = OWN_W'(k);
        end
      end
    end
  end

`ifdef SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/bram_load_scheduler.sv
// Shares one read-only BRAM between NUM_REQ burst loaders; returns words tagged
// with owner and index. Arbitration policy selected by SCHED_FIXED_PRIO_EN.
module bram_load_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 18,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int OWN_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          data_valid,
  output logic [W-1:0]                  data_out,
  output logic [LEN_WIDTH-1:0]          data_idx,
  output logic [OWN_W-1:0]              data_owner,
  output logic                          busy,
  output logic                          bram_en,
  output logic                          bram_ren,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [W-1:0]                  bram_dout
);

  sched_state_e          state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q, win_base;
  logic [LEN_WIDTH-1:0]  len_q, issued_q, emit_q, win_len;
  logic [OWN_W-1:0]      owner_q, rr_ptr_q, arb_idx;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic                  arb_any, start;
  logic [RD_LATENCY-1:0] tag_q;
  logic [RD_LATENCY:0]   tag_in;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .OWN_W(OWN_W)) u_arb (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    win_base = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_base = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign start      = (state_q == S_IDLE) && arb_any;
  assign tag_in     = {tag_q, bram_ren};
  assign data_valid = tag_q[RD_LATENCY-1];
  assign data_owner = owner_q;

  always_comb begin
    state_nxt = state_q;
    busy      = 1'b1;
    bram_en   = 1'b0;
    bram_ren  = 1'b0;
    bram_addr = '0;
    done      = '0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (arb_any) state_nxt = (win_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        bram_en   = 1'b1;
        bram_ren  = 1'b1;
        bram_addr = base_q + ADDR_WIDTH'(issued_q);
        if (issued_q == len_q - LEN_WIDTH'(1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bram_en = 1'b1;
        if (data_valid && data_idx == len_q - LEN_WIDTH'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        bram_en   = 1'b1;
        done      = grant;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage boundary: tag pipeline entry at tag_in[0], word capture one stage
  // before the tag exits so data_valid lines up RD_LATENCY cycles after addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      emit_q   <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      tag_q    <= '0;
      grant    <= '0;
      data_out <= '0;
      data_idx <= '0;
    end else begin
      state_q <= state_nxt;
      tag_q   <= tag_in[RD_LATENCY-1:0];
      if (tag_in[RD_LATENCY-1]) begin
        data_out <= bram_dout;
        data_idx <= emit_q;
        emit_q   <= emit_q + LEN_WIDTH'(1);
      end
      if (start) begin
        base_q   <= win_base;
        len_q    <= win_len;
        owner_q  <= arb_idx;
        grant    <= arb_gnt;
        issued_q <= '0;
        emit_q   <= '0;
      end
      if (state_q == S_ISSUE) issued_q <= issued_q + LEN_WIDTH'(1);
      if (state_q == S_DONE) begin
        grant    <= '0;
        rr_ptr_q <= (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
      end
    end
  end

endmodule
